wb_port_sched: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_req_buf.sv | 53 +++++
 rtl/wb_port_sched.sv | 110 +++++++++++
 tb/tb_wb_port_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback port scheduler.
package wb_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned PORT_LOAD  = 0;
  localparam int unsigned PORT_ALU   = 1;
  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned CNT_W      = 2;
endpackage

// File: rtl/wb_req_buf.sv
// Two-entry request FIFO; ready depends on the registered count only.
module wb_req_buf
  import wb_pkg::*;
#(
  parameter int unsigned W = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_din,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ready,
  output logic             o_empty
);

  logic [W-1:0]     r_mem [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count < CNT_W'(BUF_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & o_ready;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wb_port_sched.sv
// Arbitrates load (port 0) and ALU (port 1) writeback buffers onto one
// registered register-file write port.
module wb_port_sched
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_stall,
  output logic              wb_idle
);

  localparam int unsigned REQ_W = ADDR_W + DATA_W;

  logic [REQ_W-1:0]  w_head0, w_head1;
  logic [CNT_W-1:0]  w_cnt0, w_cnt1;
  logic              w_ready0, w_ready1;
  logic              w_empty0, w_empty1;
  logic [ADDR_W-1:0] w_addr0, w_addr1, w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_grant0, w_grant1, w_grant;

  logic              r_rr_last;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  wb_req_buf #(.W(REQ_W)) u_buf0 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (p0_valid),
    .i_pop   (w_grant0),
    .i_din   ({p0_addr, p0_data}),
    .o_head  (w_head0),
    .o_count (w_cnt0),
    .o_ready (w_ready0),
    .o_empty (w_empty0)
  );

  wb_req_buf #(.W(REQ_W)) u_buf1 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (p1_valid),
    .i_pop   (w_grant1),
    .i_din   ({p1_addr, p1_data}),
    .o_head  (w_head1),
    .o_count (w_cnt1),
    .o_ready (w_ready1),
    .o_empty (w_empty1)
  );

  assign w_addr0 = w_head0[REQ_W-1 -: ADDR_W];
  assign w_addr1 = w_head1[REQ_W-1 -: ADDR_W];

  // Equal destinations go to the older load; otherwise alternate away from rr_last.
  assign w_grant0 = ~w_empty0 &
                    (w_empty1 | (w_addr0 == w_addr1) | (r_rr_last != 1'(PORT_LOAD)));
  assign w_grant1 = ~w_empty1 & ~w_grant0;
  assign w_grant  = w_grant0 | w_grant1;

  always_comb begin
    w_sel_addr = w_addr0;
    w_sel_data = w_head0[DATA_W-1:0];
    if (w_grant1) begin
      w_sel_addr = w_addr1;
      w_sel_data = w_head1[DATA_W-1:0];
    end
  end

  // Writes to register zero consume their slot but never reach the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_last  <= 1'(PORT_ALU);
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_grant & (w_sel_addr != ADDR_W'(REG_ZERO));
      if (w_grant) begin
        r_rr_last <= w_grant1 ? 1'(PORT_ALU) : 1'(PORT_LOAD);
      end
      if (w_grant && (w_sel_addr != ADDR_W'(REG_ZERO))) begin
        r_rf_waddr <= w_sel_addr;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign p0_ready = w_ready0;
  assign p1_ready = w_ready1;
  assign wb_stall = ~w_ready0 | ~w_ready1;
  assign wb_idle  = (w_cnt0 == '0) & (w_cnt1 == '0) & ~r_rf_we;

endmodule

// File: tb/tb_wb_port_sched.sv
// Scoreboard bench for wb_port_sched: expected writes queued at stimulus time.
module tb_wb_port_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       p0_valid, p1_valid;
  logic [2:0] p0_addr, p1_addr;
  logic [7:0] p0_data, p1_data;
  logic       p0_ready, p1_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       wb_stall, wb_idle;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  wb_port_sched dut (
    .clk      (clk),
    .reset    (reset),
    .p0_valid (p0_valid),
    .p0_addr  (p0_addr),
    .p0_data  (p0_data),
    .p0_ready (p0_ready),
    .p1_valid (p1_valid),
    .p1_addr  (p1_addr),
    .p1_data  (p1_data),
    .p1_ready (p1_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_stall (wb_stall),
    .wb_idle  (wb_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          failures++;
          $display("FAIL write_order: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   rf_waddr, rf_wdata, e[10:8], e[7:0]);
        end
      end
    end
  end

  task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic cyc(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [2:0] a1, input logic [7:0] d1);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
    p1_valid = 1'b0; p1_addr = '0; p1_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", int'(rf_we), 0);
    chk("rst_p0_ready", int'(p0_ready), 1);
    chk("rst_p1_ready", int'(p1_ready), 1);
    chk("rst_idle", int'(wb_idle), 1);
    chk("rst_stall", int'(wb_stall), 0);
    chk("rst_waddr", int'(rf_waddr), 0);
    chk("rst_wdata", int'(rf_wdata), 0);
    reset = 1'b1;

    // Single ALU write: accept edge k, write visible after edge k+1 for one cycle
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h5A);
    expect_wr(3'd3, 8'h5A);
    chk("single_idle_busy", int'(wb_idle), 0);
    idle(1);
    chk("single_we", int'(rf_we), 1);
    chk("single_waddr", int'(rf_waddr), 3);
    idle(1);
    chk("single_we_drop", int'(rf_we), 0);
    chk("single_idle", int'(wb_idle), 1);

    // Contention: round-robin gives 2,5,4,6
    do_reset();
    cyc(1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h33);
    cyc(1'b1, 3'd4, 8'h22, 1'b1, 3'd6, 8'h44);
    expect_wr(3'd2, 8'h11);
    expect_wr(3'd5, 8'h33);
    expect_wr(3'd4, 8'h22);
    expect_wr(3'd6, 8'h44);
    idle(6);
    chk("contend_drained", exp_q.size(), 0);

    // Same address: load first, then ALU
    do_reset();
    cyc(1'b1, 3'd3, 8'hAA, 1'b1, 3'd3, 8'hBB);
    expect_wr(3'd3, 8'hAA);
    expect_wr(3'd3, 8'hBB);
    idle(4);
    chk("sameaddr_drained", exp_q.size(), 0);

    // Full/stall: third ALU push lands on a full buffer and is dropped
    do_reset();
    expect_wr(3'd1, 8'h01);
    expect_wr(3'd2, 8'h02);
    expect_wr(3'd3, 8'h03);
    expect_wr(3'd4, 8'h04);
    expect_wr(3'd5, 8'h05);
    cyc(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02);
    chk("full_p1_ready_1", int'(p1_ready), 1);
    cyc(1'b1, 3'd3, 8'h03, 1'b1, 3'd4, 8'h04);
    chk("full_p1_ready_0", int'(p1_ready), 0);
    chk("full_stall_1", int'(wb_stall), 1);
    chk("full_p0_ready", int'(p0_ready), 1);
    cyc(1'b1, 3'd5, 8'h05, 1'b1, 3'd6, 8'h06);
    chk("full_p1_ready_back", int'(p1_ready), 1);
    chk("full_p0_ready_0", int'(p0_ready), 0);
    chk("full_stall_2", int'(wb_stall), 1);
    idle(8);
    chk("full_drained", exp_q.size(), 0);
    chk("full_idle", int'(wb_idle), 1);
    chk("full_stall_clear", int'(wb_stall), 0);

    // Register zero consumes a slot without writing; then reset mid-operation
    do_reset();
    cyc(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00);
    chk("zero_busy", int'(wb_idle), 0);
    idle(1);
    chk("zero_we", int'(rf_we), 0);
    chk("zero_idle", int'(wb_idle), 1);
    cyc(1'b1, 3'd1, 8'h61, 1'b1, 3'd2, 8'h62);
    cyc(1'b1, 3'd3, 8'h63, 1'b1, 3'd4, 8'h64);
    expect_wr(3'd2, 8'h62);
    chk("zero_rr_we", int'(rf_we), 1);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we", int'(rf_we), 0);
    chk("midrst_waddr", int'(rf_waddr), 0);
    chk("midrst_wdata", int'(rf_wdata), 0);
    chk("midrst_idle", int'(wb_idle), 1);
    chk("midrst_p0_ready", int'(p0_ready), 1);
    chk("midrst_p1_ready", int'(p1_ready), 1);
    reset = 1'b1;
    idle(4);
    chk("midrst_still_idle", int'(wb_idle), 1);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
